// File: rtl/cpu_pkg.sv
// Shared encodings for the core's back end: write-back source select,
// load funct3 codes and the write-back FSM state type.
package cpu_pkg;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        WB_IDLE    = 1'b0,
        WB_WAIT_LD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/load_formatter.sv
// Extracts the addressed byte/half/word from an aligned load word and
// sign- or zero-extends it to XLEN. Purely combinational.
module load_formatter
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] word_i,
    output logic [XLEN-1:0] result_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection: byte by full offset, half by off[1] only
    always_comb begin
        byte_s = word_i[{off_i, 3'b000} +: 8];
        if (off_i[1]) begin
            half_s = word_i[16 +: 16];
        end else begin
            half_s = word_i[0 +: 16];
        end
    end

    // Extension by funct3; anything undefined behaves as LW
    always_comb begin
        result_o = word_i;
        case (funct3_i)
            F3_LB:   result_o = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_LH:   result_o = {{(XLEN-16){half_s[15]}}, half_s};
            F3_LBU:  result_o = {{(XLEN-8){1'b0}}, byte_s};
            F3_LHU:  result_o = {{(XLEN-16){1'b0}}, half_s};
            F3_LW:   result_o = word_i;
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: selects the retiring result, waits for load data
// when needed, and drives the register-file write port and retire counter.
module writeback_stage
    import cpu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [1:0]        in_wb_sel,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_pc_plus4,
    input  logic [2:0]        in_ld_funct3,
    input  logic              ld_rsp_valid,
    input  logic [XLEN-1:0]   ld_rsp_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_a3,
    output logic [XLEN-1:0]   rf_wd,
    output logic [CNT_W-1:0]  instret,
    output logic              err_spurious
);

    wb_state_t         state_q,   state_d;
    logic              ld_rw_q,   ld_rw_d;
    logic [REG_AW-1:0] ld_rd_q,   ld_rd_d;
    logic [2:0]        ld_f3_q,   ld_f3_d;
    logic [1:0]        ld_off_q,  ld_off_d;
    logic              rf_we_q,   rf_we_d;
    logic [REG_AW-1:0] rf_a3_q,   rf_a3_d;
    logic [XLEN-1:0]   rf_wd_q,   rf_wd_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              err_q,     err_d;

    logic              commit_s;
    logic              commit_rw_s;
    logic [REG_AW-1:0] commit_rd_s;
    logic [XLEN-1:0]   commit_data_s;
    logic [XLEN-1:0]   direct_res_s;
    logic [XLEN-1:0]   load_res_s;

    load_formatter #(.XLEN(XLEN)) u_fmt (
        .funct3_i (ld_f3_q),
        .off_i    (ld_off_q),
        .word_i   (ld_rsp_data),
        .result_o (load_res_s)
    );

    // Non-load result source; the reserved encoding falls back to ALU
    always_comb begin
        case (in_wb_sel)
            WB_PC4:  direct_res_s = in_pc_plus4;
            WB_ALU:  direct_res_s = in_alu_result;
            default: direct_res_s = in_alu_result;
        endcase
    end

    // Next-state: FSM transitions, load context capture and commit selection
    always_comb begin
        state_d       = state_q;
        ld_rw_d       = ld_rw_q;
        ld_rd_d       = ld_rd_q;
        ld_f3_d       = ld_f3_q;
        ld_off_d      = ld_off_q;
        err_d         = err_q;
        commit_s      = 1'b0;
        commit_rw_s   = 1'b0;
        commit_rd_s   = {REG_AW{1'b0}};
        commit_data_s = {XLEN{1'b0}};
        case (state_q)
            WB_IDLE: begin
                if (ld_rsp_valid) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (in_valid && (in_wb_sel == WB_LOAD)) begin
                    ld_rw_d  = in_reg_write;
                    ld_rd_d  = in_rd;
                    ld_f3_d  = in_ld_funct3;
                    ld_off_d = in_alu_result[1:0];
                    state_d  = WB_WAIT_LD;
                end else if (in_valid) begin
                    commit_s      = 1'b1;
                    commit_rw_s   = in_reg_write;
                    commit_rd_s   = in_rd;
                    commit_data_s = direct_res_s;
                end else begin
                    state_d = WB_IDLE;
                end
            end
            WB_WAIT_LD: begin
                if (ld_rsp_valid) begin
                    commit_s      = 1'b1;
                    commit_rw_s   = ld_rw_q;
                    commit_rd_s   = ld_rd_q;
                    commit_data_s = load_res_s;
                    state_d       = WB_IDLE;
                end else begin
                    state_d = WB_WAIT_LD;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // Commit: every retirement counts, but x0 / no-write leaves the port idle
    always_comb begin
        rf_we_d   = 1'b0;
        rf_a3_d   = rf_a3_q;
        rf_wd_d   = rf_wd_q;
        instret_d = instret_q;
        if (commit_s) begin
            instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (commit_rw_s && (commit_rd_s != {REG_AW{1'b0}})) begin
                rf_we_d = 1'b1;
                rf_a3_d = commit_rd_s;
                rf_wd_d = commit_data_s;
            end else begin
                rf_we_d = 1'b0;
            end
        end else begin
            instret_d = instret_q;
        end
    end

    // State, load context and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= WB_IDLE;
            ld_rw_q   <= 1'b0;
            ld_rd_q   <= {REG_AW{1'b0}};
            ld_f3_q   <= 3'b000;
            ld_off_q  <= 2'b00;
            rf_we_q   <= 1'b0;
            rf_a3_q   <= {REG_AW{1'b0}};
            rf_wd_q   <= {XLEN{1'b0}};
            instret_q <= {CNT_W{1'b0}};
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_rw_q   <= ld_rw_d;
            ld_rd_q   <= ld_rd_d;
            ld_f3_q   <= ld_f3_d;
            ld_off_q  <= ld_off_d;
            rf_we_q   <= rf_we_d;
            rf_a3_q   <= rf_a3_d;
            rf_wd_q   <= rf_wd_d;
            instret_q <= instret_d;
            err_q     <= err_d;
        end
    end

    assign in_ready     = (state_q == WB_IDLE);
    assign rf_we        = rf_we_q;
    assign rf_a3        = rf_a3_q;
    assign rf_wd        = rf_wd_q;
    assign instret      = instret_q;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected commits are queued when
// stimulus is driven and compared when the stage retires them.
module tb_writeback_stage;
    import cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic [2:0]  in_ld_funct3;
    logic        ld_rsp_valid;
    logic [31:0] ld_rsp_data;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [63:0] instret;
    logic        err_spurious;

    writeback_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg_write  (in_reg_write),
        .in_rd         (in_rd),
        .in_wb_sel     (in_wb_sel),
        .in_alu_result (in_alu_result),
        .in_pc_plus4   (in_pc_plus4),
        .in_ld_funct3  (in_ld_funct3),
        .ld_rsp_valid  (ld_rsp_valid),
        .ld_rsp_data   (ld_rsp_data),
        .rf_we         (rf_we),
        .rf_a3         (rf_a3),
        .rf_wd         (rf_wd),
        .instret       (instret),
        .err_spurious  (err_spurious)
    );

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [63:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          total_cnt;
    int          bad_cnt;
    logic [63:0] exp_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic we, input logic [4:0] a3, input logic [31:0] wd);
        exp_t e;
        exp_cnt  = exp_cnt + 64'd1;
        e.we     = we;
        e.a3     = a3;
        e.wd     = wd;
        e.cnt    = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3);
        @(negedge clk);
        check("ready_issue", 64'(in_ready), 64'd1);
        in_valid      = 1'b1;
        in_reg_write  = rw;
        in_rd         = rd;
        in_wb_sel     = sel;
        in_alu_result = alu;
        in_pc_plus4   = pc4;
        in_ld_funct3  = f3;
        if (sel != WB_LOAD) begin
            push_exp(rw && (rd != 5'd0), rd, (sel == WB_PC4) ? pc4 : alu);
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid     = 1'b0;
        ld_rsp_valid = 1'b0;
    endtask

    task automatic load_op(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] word, input int delay, input logic [31:0] exp);
        logic [31:0] addr;
        addr = ($urandom() & 32'hFFFF_FFFC) | {30'd0, off};
        issue(1'b1, rd, WB_LOAD, addr, 32'h0, f3);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            in_valid      = 1'b0;
            in_alu_result = $urandom();
            in_ld_funct3  = 3'(i);
            check("ready_wait", 64'(in_ready), 64'd0);
            if (i == delay - 1) begin
                ld_rsp_valid = 1'b1;
                ld_rsp_data  = word;
                push_exp(1'b1, rd, exp);
            end
        end
        @(negedge clk);
        ld_rsp_valid = 1'b0;
        ld_rsp_data  = $urandom();
    endtask

    // Monitor: a commit is any rf_we pulse or change of instret
    initial begin
        logic [63:0] last;
        exp_t        e;
        last = 64'd0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                last = 64'd0;
            end else if (rf_we || (instret != last)) begin
                last = instret;
                if (sb.size() == 0) begin
                    check("unexpected_commit", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("we", 64'(rf_we), 64'(e.we));
                    check("instret", instret, e.cnt);
                    if (e.we) begin
                        check("a3", 64'(rf_a3), 64'(e.a3));
                        check("wd", 64'(rf_wd), 64'(e.wd));
                    end
                end
            end
        end
    end

    initial begin
        total_cnt     = 0;
        bad_cnt       = 0;
        exp_cnt       = 64'd0;
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_reg_write  = 1'b0;
        in_rd         = 5'd0;
        in_wb_sel     = WB_ALU;
        in_alu_result = 32'd0;
        in_pc_plus4   = 32'd0;
        in_ld_funct3  = 3'd0;
        ld_rsp_valid  = 1'b0;
        ld_rsp_data   = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_we", 64'(rf_we), 64'd0);
        check("rst_a3", 64'(rf_a3), 64'd0);
        check("rst_wd", 64'(rf_wd), 64'd0);
        check("rst_instret", instret, 64'd0);
        check("rst_err", 64'(err_spurious), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        issue(1'b1, 5'd5, WB_ALU, 32'h1234_5678, 32'h0, 3'd0);
        go_idle();

        issue(1'b1, 5'd1, WB_ALU, 32'hAAAA_0001, 32'h0, 3'd0);
        issue(1'b1, 5'd2, WB_ALU, 32'hBBBB_0002, 32'h0, 3'd0);
        issue(1'b1, 5'd3, 2'b11,  32'hCCCC_0003, 32'hDEAD_BEEF, 3'd0);
        go_idle();

        load_op(5'd10, F3_LB,  2'd3, 32'h80FF_0000, 4, 32'hFFFF_FF80);
        load_op(5'd11, F3_LBU, 2'd3, 32'h80FF_0000, 4, 32'h0000_0080);
        load_op(5'd12, F3_LH,  2'd2, 32'h8001_7FFF, 2, 32'hFFFF_8001);
        load_op(5'd13, F3_LHU, 2'd3, 32'h8001_7FFF, 1, 32'h0000_8001);
        load_op(5'd14, F3_LW,  2'd1, 32'h8001_7FFF, 3, 32'h8001_7FFF);
        load_op(5'd15, F3_LB,  2'd0, 32'h1234_56FF, 1, 32'hFFFF_FFFF);
        load_op(5'd16, F3_LH,  2'd1, 32'h1234_F00D, 1, 32'hFFFF_F00D);
        load_op(5'd17, 3'b111, 2'd2, 32'hCAFE_F00D, 2, 32'hCAFE_F00D);

        issue(1'b1, 5'd0, WB_ALU, 32'h5555_5555, 32'h0, 3'd0);
        issue(1'b1, 5'd1, WB_PC4, 32'h7777_7777, 32'h0000_0104, 3'd0);
        issue(1'b0, 5'd4, WB_ALU, 32'h9999_9999, 32'h0, 3'd0);
        go_idle();
        repeat (2) @(negedge clk);

        check("err_before", 64'(err_spurious), 64'd0);
        @(negedge clk);
        ld_rsp_valid = 1'b1;
        ld_rsp_data  = 32'hFFFF_FFFF;
        @(negedge clk);
        ld_rsp_valid = 1'b0;
        check("err_spurious", 64'(err_spurious), 64'd1);
        check("no_we_spurious", 64'(rf_we), 64'd0);

        issue(1'b1, 5'd7, WB_LOAD, 32'h0000_0000, 32'h0, F3_LW);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_we", 64'(rf_we), 64'd0);
        check("midrst_a3", 64'(rf_a3), 64'd0);
        check("midrst_wd", 64'(rf_wd), 64'd0);
        check("midrst_instret", instret, 64'd0);
        check("midrst_err", 64'(err_spurious), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd1);
        exp_cnt = 64'd0;
        rst     = 1'b0;
        @(negedge clk);
        ld_rsp_valid = 1'b1;
        ld_rsp_data  = 32'h1111_2222;
        @(negedge clk);
        ld_rsp_valid = 1'b0;
        check("late_rsp_err", 64'(err_spurious), 64'd1);
        check("late_rsp_instret", instret, 64'd0);

        issue(1'b1, 5'd9, WB_ALU, 32'h0BAD_F00D, 32'h0, 3'd0);
        go_idle();
        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
